// File: rtl/pfs_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pfs_pkg
//  Brief    : Shared types and default constants for the packet fetch
//             scheduler (PFS) WRR block.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
package pfs_pkg;

    // Default configuration of the scheduler.
    localparam int C_NUM_PORTS  = 16;
    localparam int C_CREDIT_W   = 6;
    localparam int C_WEIGHT_W   = 4;
    // Port field width of the fetch request record; it covers up to 256 ports.
    localparam int C_PORT_W_MAX = 8;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_ARB  = 2'd1,
        ST_HOLD = 2'd2
    } pfs_state_e;

    // Fetch request currently presented to PRC.
    typedef struct packed {
        logic [C_PORT_W_MAX-1:0] port;
        logic                    valid;
    } fetch_req_t;

endpackage : pfs_pkg
`default_nettype wire

// File: rtl/pfs_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : pfs_rr_arb
//  Brief    : Combinational rotating-priority find-first-set. Searches the
//             eligible vector starting strictly after ptr and wrapping; ptr
//             itself is the last candidate.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module pfs_rr_arb
    import pfs_pkg::*;
#(
    parameter int NUM_PORTS = C_NUM_PORTS,
    parameter int PORT_W    = 4
) (
    input  logic [NUM_PORTS-1:0] elig,
    input  logic [PORT_W-1:0]    ptr,
    output logic [PORT_W-1:0]    grant,
    output logic                 found
);

    logic [PORT_W-1:0] w_idx;

    // Walk from the farthest candidate to the nearest so the nearest wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        w_idx = '0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            w_idx = PORT_W'((int'(ptr) + i) % NUM_PORTS);
            if (elig[w_idx]) begin
                grant = w_idx;
                found = 1'b1;
            end
        end
    end

endmodule : pfs_rr_arb
`default_nettype wire

// File: rtl/pfs_wrr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : pfs_wrr_sched
//  Brief    : Packet fetch scheduler. Weighted round robin over egress ports
//             gated by per-port PRC credits; one valid/ready fetch per cycle
//             and a one-hot pop back to DPB on each handshake.
//  Options  : PFS_STRICT_PRIO_EN - adds cfg_sp_mask; masked eligible ports win
//             lowest-index-first without touching quota or rr pointer.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module pfs_wrr_sched
    import pfs_pkg::*;
#(
    parameter  int NUM_PORTS = C_NUM_PORTS,
    parameter  int CREDIT_W  = C_CREDIT_W,
    parameter  int WEIGHT_W  = C_WEIGHT_W,
    localparam int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req_valid,
    output logic [NUM_PORTS-1:0]          req_ack,
    input  logic [NUM_PORTS*WEIGHT_W-1:0] cfg_weight,
    input  logic [CREDIT_W-1:0]           cfg_credit_init,
`ifdef PFS_STRICT_PRIO_EN
    input  logic [NUM_PORTS-1:0]          cfg_sp_mask,
`endif
    input  logic                          credit_ret_valid,
    input  logic [PORT_W-1:0]             credit_ret_port,
    output logic                          fetch_valid,
    output logic [PORT_W-1:0]             fetch_port,
    input  logic                          fetch_ready,
    output logic                          err_credit_ovf,
    output logic                          idle
);

    pfs_state_e          r_state, w_state_nxt;
    logic [CREDIT_W-1:0] r_credit [NUM_PORTS];
    logic [CREDIT_W-1:0] r_credit_init;
    logic [PORT_W-1:0]   r_ptr;
    logic [WEIGHT_W-1:0] r_quota;
    fetch_req_t          r_fetch;
    logic                r_sp;
    logic                r_ovf;

    logic                w_hs;
    logic                w_ret_ok;
    logic [NUM_PORTS-1:0] w_consume, w_return, w_ret_drop;
    logic [NUM_PORTS-1:0] w_elig_cur, w_elig_post, w_sel_elig;
    logic [CREDIT_W-1:0] w_credit_nxt [NUM_PORTS];
    logic [WEIGHT_W-1:0] w_weight [NUM_PORTS];
    logic [WEIGHT_W-1:0] w_quota_post, w_quota_nxt;
    logic                w_keep;
    logic [PORT_W-1:0]   w_rr_grant, w_sp_grant, w_win_port, w_ptr_nxt;
    logic                w_rr_found, w_sp_found, w_win_found, w_win_sp;
    logic                w_idle;
    logic                w_unused_fetch;

    assign w_hs     = (r_state == ST_HOLD) && r_fetch.valid && fetch_ready;
    assign w_ret_ok = credit_ret_valid && (r_state != ST_INIT);

    // Per-port credit arithmetic and eligibility, both current and post-handshake.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign w_weight[p]   = cfg_weight[p*WEIGHT_W +: WEIGHT_W];
        assign w_consume[p]  = w_hs && (r_fetch.port == C_PORT_W_MAX'(p));
        assign w_return[p]   = w_ret_ok && (credit_ret_port == PORT_W'(p));
        // A return with a same-cycle consume nets out and is never an overflow.
        assign w_ret_drop[p] = w_return[p] && !w_consume[p] && (r_credit[p] == r_credit_init);
        assign w_credit_nxt[p] =
            (w_consume[p] && !w_return[p])                  ? r_credit[p] - CREDIT_W'(1) :
            (w_return[p] && !w_consume[p] && !w_ret_drop[p]) ? r_credit[p] + CREDIT_W'(1) :
                                                               r_credit[p];
        assign w_elig_cur[p]  = req_valid[p] && (r_credit[p] != '0)     && (w_weight[p] != '0);
        assign w_elig_post[p] = req_valid[p] && (w_credit_nxt[p] != '0) && (w_weight[p] != '0);
    end

    // On a handshake the next winner is picked from post-handshake state.
    assign w_sel_elig   = w_hs ? w_elig_post : w_elig_cur;
    assign w_quota_post = (w_hs && !r_sp && (r_quota != '0)) ? r_quota - WEIGHT_W'(1) : r_quota;
    assign w_keep       = (w_quota_post != '0) && w_sel_elig[r_ptr];

    pfs_rr_arb #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_rr_arb (
        .elig  (w_sel_elig),
        .ptr   (r_ptr),
        .grant (w_rr_grant),
        .found (w_rr_found)
    );

`ifdef PFS_STRICT_PRIO_EN
    logic [NUM_PORTS-1:0] w_sp_elig;
    assign w_sp_elig = w_sel_elig & cfg_sp_mask;

    // Lowest-index strict-priority port among the eligible masked set.
    always_comb begin
        w_sp_found = 1'b0;
        w_sp_grant = '0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if (w_sp_elig[p]) begin
                w_sp_found = 1'b1;
                w_sp_grant = PORT_W'(p);
            end
        end
    end
`else
    assign w_sp_found = 1'b0;
    assign w_sp_grant = '0;
`endif

    // Winner resolution: strict priority, then quota hold, then rotation.
    always_comb begin
        w_win_found = 1'b0;
        w_win_port  = r_ptr;
        w_win_sp    = 1'b0;
        w_ptr_nxt   = r_ptr;
        w_quota_nxt = w_quota_post;
        if (w_sp_found) begin
            w_win_found = 1'b1;
            w_win_port  = w_sp_grant;
            w_win_sp    = 1'b1;
        end else if (w_keep) begin
            w_win_found = 1'b1;
        end else if (w_rr_found) begin
            w_win_found = 1'b1;
            w_win_port  = w_rr_grant;
            w_ptr_nxt   = w_rr_grant;
            w_quota_nxt = w_weight[w_rr_grant];
        end
    end

    // Next-state and idle decode.
    always_comb begin
        w_state_nxt = r_state;
        w_idle      = 1'b0;
        case (r_state)
            ST_INIT: w_state_nxt = ST_ARB;
            ST_ARB: begin
                w_idle = !w_win_found;
                if (w_win_found) w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (w_hs && !w_win_found) w_state_nxt = ST_ARB;
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // State, credits, WRR bookkeeping and the presented fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_INIT;
            r_credit_init <= '0;
            r_ptr         <= '0;
            r_quota       <= '0;
            r_fetch       <= '0;
            r_sp          <= 1'b0;
            r_ovf         <= 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) r_credit[p] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ovf   <= r_ovf | (|w_ret_drop);
            if (r_state == ST_INIT) r_credit_init <= cfg_credit_init;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_credit[p] <= (r_state == ST_INIT) ? cfg_credit_init : w_credit_nxt[p];
            end
            if ((r_state == ST_ARB) || w_hs) begin
                r_ptr         <= w_ptr_nxt;
                r_quota       <= w_quota_nxt;
                r_sp          <= w_win_sp;
                r_fetch.valid <= w_win_found;
                if (w_win_found) r_fetch.port <= C_PORT_W_MAX'(w_win_port);
            end
        end
    end

    assign req_ack        = w_consume;
    assign fetch_valid    = r_fetch.valid;
    assign fetch_port     = r_fetch.port[PORT_W-1:0];
    assign err_credit_ovf = r_ovf;
    assign idle           = w_idle;
    assign w_unused_fetch = ^r_fetch.port;

endmodule : pfs_wrr_sched
`default_nettype wire

// File: tb/tb_pfs_wrr_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pfs_wrr_sched
//  Brief    : Directed self-checking bench for pfs_wrr_sched (16 ports,
//             6-bit credits, 4-bit weights).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pfs_wrr_sched;

    localparam int NP = 16;
    localparam int CW = 6;
    localparam int WW = 4;
    localparam int PW = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NP-1:0]    req_valid = '0;
    logic [NP-1:0]    req_ack;
    logic [NP*WW-1:0] cfg_weight = '0;
    logic [CW-1:0]    cfg_credit_init = '0;
    logic             credit_ret_valid = 1'b0;
    logic [PW-1:0]    credit_ret_port = '0;
    logic             fetch_valid;
    logic [PW-1:0]    fetch_port;
    logic             fetch_ready = 1'b0;
    logic             err_credit_ovf;
    logic             idle;
`ifdef PFS_STRICT_PRIO_EN
    logic [NP-1:0]    cfg_sp_mask = '0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_ack;

    always #5 clk = ~clk;

    pfs_wrr_sched dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ack          (req_ack),
        .cfg_weight       (cfg_weight),
        .cfg_credit_init  (cfg_credit_init),
`ifdef PFS_STRICT_PRIO_EN
        .cfg_sp_mask      (cfg_sp_mask),
`endif
        .credit_ret_valid (credit_ret_valid),
        .credit_ret_port  (credit_ret_port),
        .fetch_valid      (fetch_valid),
        .fetch_port       (fetch_port),
        .fetch_ready      (fetch_ready),
        .err_credit_ovf   (err_credit_ovf),
        .idle             (idle)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all_weights(input int w);
        for (int p = 0; p < NP; p++) cfg_weight[p*WW +: WW] = WW'(w);
    endtask

    task automatic do_reset(input int init);
        cfg_credit_init = CW'(init);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int exp2 [6] = '{0, 0, 1, 0, 0, 1};
        int exp7 [4] = '{7, 7, 1, 1};
        set_all_weights(1);
        #1;

        // Reset values and one-cycle INIT.
        req_valid = '0;
        do_reset(4);
        check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        check("rst_fetch_port", 32'(fetch_port), 32'd0);
        check("rst_req_ack", 32'(req_ack), 32'd0);
        check("rst_ovf", 32'(err_credit_ovf), 32'd0);
        check("rst_idle_init", 32'(idle), 32'd0);
        tick();
        check("arb_idle", 32'(idle), 32'd1);

        // Port 3 with 4 credits: exactly 4 back-to-back fetches.
        req_valid   = 16'h0008;
        fetch_ready = 1'b1;
        do_reset(4);
        tick();
        check("t1_lat0", 32'(fetch_valid), 32'd0);
        n_ack = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) check("t1_lat1", 32'({fetch_valid, fetch_port}), 32'h13);
            if (req_ack == 16'h0008) n_ack++;
        end
        check("t1_ackcnt", 32'(n_ack), 32'd4);
        check("t1_valid_end", 32'(fetch_valid), 32'd0);
        check("t1_idle_end", 32'(idle), 32'd1);

        // WRR weights 2/1 on ports 0/1; prime pointer onto port 1 first.
        fetch_ready = 1'b0;
        req_valid   = '0;
        cfg_weight[0 +: WW] = 4'd2;
        do_reset(20);
        tick();
        req_valid = 16'h0002;
        tick();
        check("t2_prime", 32'({fetch_valid, fetch_port}), 32'h11);
        req_valid   = 16'h0003;
        fetch_ready = 1'b1;
        #1;
        check("t2_prime_ack", 32'(req_ack), 32'h2);
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("t2_seq%0d", i), 32'({fetch_valid, fetch_port}), 32'(16 + exp2[i]));
            check($sformatf("t2_ack%0d", i), 32'(req_ack), 32'(1 << exp2[i]));
        end
        set_all_weights(1);

        // fetch_ready low 5 cycles on port 5, handshake on the 6th.
        fetch_ready = 1'b0;
        req_valid   = 16'h0020;
        do_reset(4);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t3_hold%0d", i), 32'({fetch_valid, fetch_port, req_ack}), 32'({1'b1, 4'd5, 16'h0}));
        end
        fetch_ready = 1'b1;
        #1;
        check("t3_hs", 32'(req_ack), 32'h20);
        n_ack = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (req_ack == 16'h0020) n_ack++;
        end
        check("t3_ackcnt", 32'(n_ack), 32'd4);

        // Credit netting and sticky overflow with init=1 on port 2.
        fetch_ready = 1'b0;
        req_valid   = 16'h0004;
        do_reset(1);
        tick();
        tick();
        check("t4_present", 32'({fetch_valid, fetch_port}), 32'h12);
        fetch_ready      = 1'b1;
        credit_ret_valid = 1'b1;
        credit_ret_port  = 4'd2;
        #1;
        check("t4_ack", 32'(req_ack), 32'h4);
        tick();
        fetch_ready = 1'b0;
        check("t4_net0", 32'({fetch_valid, fetch_port}), 32'h12);
        check("t4_no_ovf", 32'(err_credit_ovf), 32'd0);
        tick();
        credit_ret_valid = 1'b0;
        check("t4_ovf", 32'(err_credit_ovf), 32'd1);
        tick();
        tick();
        tick();
        check("t4_ovf_sticky", 32'(err_credit_ovf), 32'd1);

        // Pointer wrap: 15 then 0 with unit weights.
        req_valid = 16'h8000;
        do_reset(8);
        check("t5_ovf_cleared", 32'(err_credit_ovf), 32'd0);
        tick();
        tick();
        check("t5_p15", 32'({fetch_valid, fetch_port}), 32'h1F);
        req_valid   = 16'h8001;
        fetch_ready = 1'b1;
        tick();
        check("t5_wrap0", 32'({fetch_valid, fetch_port}), 32'h10);
        tick();
        check("t5_back15", 32'({fetch_valid, fetch_port}), 32'h1F);
        tick();
        check("t5_again0", 32'({fetch_valid, fetch_port}), 32'h10);

        // Reset during HOLD with one credit already consumed.
        fetch_ready = 1'b0;
        req_valid   = 16'h0200;
        do_reset(3);
        tick();
        tick();
        fetch_ready = 1'b1;
        tick();
        fetch_ready = 1'b0;
        #1;
        check("t6_in_hold", 32'({fetch_valid, fetch_port}), 32'h19);
        rst = 1'b1;
        tick();
        check("t6_drop", 32'(fetch_valid), 32'd0);
        rst = 1'b0;
        fetch_ready = 1'b1;
        tick();
        check("t6_init1", 32'(fetch_valid), 32'd0);
        n_ack = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) check("t6_first", 32'({fetch_valid, fetch_port}), 32'h19);
            if (req_ack == 16'h0200) n_ack++;
        end
        check("t6_ackcnt", 32'(n_ack), 32'd3);

`ifdef PFS_STRICT_PRIO_EN
        // Strict priority port 7 drains its credits before WRR port 1.
        fetch_ready = 1'b1;
        cfg_sp_mask = 16'h0080;
        req_valid   = 16'h0082;
        do_reset(2);
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t7_seq%0d", i), 32'({fetch_valid, fetch_port}), 32'(16 + exp7[i]));
        end
        tick();
        check("t7_done", 32'(fetch_valid), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pfs_wrr_sched
`default_nettype wire
